// File: rtl/phy_tx_serializer.sv
// -----------------------------------------------------------------------------
// phy_tx_serializer
//
// Purpose:
//   Takes one encoded flit from the TX PHY manager and shifts it onto a
//   single-bit lane, LSB first, one bit per CLK. The frame is either the full
//   flit (NSYM symbols) or a shortened comma frame of 1 or 2 symbols. A
//   one-cycle done pulse follows the last bit and feeds back to the manager's
//   arbitration buffer.
//
// Ports:
//   CLK               in   1      system clock (single domain)
//   nRST              in   1      synchronous, active-low reset
//   start             in   1      1-cycle pulse; enc_flit / comma_length_sel valid
//   enc_flit          in   ENC_W  encoded frame, symbol k = [k*SYM_W +: SYM_W]
//   comma_length_sel  in   2      00 full, 01 one symbol, 10 two symbols,
//                                 11 reserved (full)
//   serial_out        out  1      lane bit, 0 when idle
//   tx_active         out  1      high while serial_out carries a frame bit
//   done              out  1      1-cycle pulse after the last frame bit
//   overrun           out  1      1-cycle pulse: start arrived while shifting
//
// States:
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_SHIFT | driving shreg_q[0] onto the lane, one bit per cycle
//   S_DONE  | done pulse; a start here is accepted just like in S_IDLE
// -----------------------------------------------------------------------------
module phy_tx_serializer #(
  parameter int NSYM  = 5,
  parameter int SYM_W = 10
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    start,
  input  logic [NSYM*SYM_W-1:0]   enc_flit,
  input  logic [1:0]              comma_length_sel,
  output logic                    serial_out,
  output logic                    tx_active,
  output logic                    done,
  output logic                    overrun
);

  localparam int ENC_W = NSYM * SYM_W;
  localparam int CNT_W = $clog2(ENC_W);

  // Frame length is kept as len-1 so the terminal compare never needs a
  // counter wider than the largest bit index.
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(ENC_W - 1);
  localparam logic [CNT_W-1:0] LAST_ONE  = CNT_W'(SYM_W - 1);
  localparam logic [CNT_W-1:0] LAST_TWO  = CNT_W'(2 * SYM_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [ENC_W-1:0]   shreg_q,   shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   last_q,    last_d;
  logic               overrun_q, overrun_d;

  function automatic logic [CNT_W-1:0] last_index(input logic [1:0] sel);
    case (sel)
      2'b01:   return LAST_ONE;
      2'b10:   return LAST_TWO;
      default: return LAST_FULL;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      last_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    overrun_d = 1'b0;

    case (state_q)
      S_SHIFT: begin
        // A start while shifting is dropped; only the overrun flag reacts.
        overrun_d = start;
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == last_q) begin
          state_d = S_DONE;
        end
      end

      default: begin
        // S_IDLE and S_DONE both accept a new frame.
        if (start) begin
          shreg_d   = enc_flit;
          last_d    = last_index(comma_length_sel);
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else begin
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  // Outputs decode directly from registered state, so they change only on
  // the clock edge.
  assign tx_active  = (state_q == S_SHIFT);
  assign serial_out = tx_active & shreg_q[0];
  assign done       = (state_q == S_DONE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
module tb_phy_tx_serializer;

  localparam int NSYM  = 5;
  localparam int SYM_W = 10;
  localparam int ENC_W = NSYM * SYM_W;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             start;
  logic [ENC_W-1:0] enc_flit;
  logic [1:0]       comma_length_sel;
  logic             serial_out;
  logic             tx_active;
  logic             done;
  logic             overrun;

  phy_tx_serializer #(.NSYM(NSYM), .SYM_W(SYM_W)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .start            (start),
    .enc_flit         (enc_flit),
    .comma_length_sel (comma_length_sel),
    .serial_out       (serial_out),
    .tx_active        (tx_active),
    .done             (done),
    .overrun          (overrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one remembered frame (start edge, length, data).
  // Outputs follow from where the current edge falls relative to that frame.
  bit               m_frame = 1'b0;
  int               m_t0    = 0;
  int               m_len   = 0;
  logic [ENC_W-1:0] m_flit  = '0;
  bit e_ser, e_act, e_done, e_ovr;

  int ovr_seen;

  typedef struct {
    logic [1:0]       sel;
    logic [ENC_W-1:0] flit;
    int               exp_bits;
    logic [ENC_W-1:0] exp_stream;
  } vec_t;

  vec_t vecs [4];

  function automatic int frame_len(input logic [1:0] s);
    case (s)
      2'b01:   return SYM_W;
      2'b10:   return 2 * SYM_W;
      default: return ENC_W;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Advance one clock edge, update the model with the inputs sampled at
  // that edge, then compare all outputs shortly after the edge.
  task automatic step();
    bit in_shift;
    @(posedge CLK);
    cyc++;
    if (!nRST) begin
      m_frame = 1'b0;
      e_ser = 0; e_act = 0; e_done = 0; e_ovr = 0;
    end else begin
      in_shift = m_frame && (cyc >= m_t0 + 1) && (cyc <= m_t0 + m_len);
      e_ovr    = start && in_shift;
      if (start && !in_shift) begin
        m_frame = 1'b1;
        m_t0    = cyc;
        m_len   = frame_len(comma_length_sel);
        m_flit  = enc_flit;
      end
      e_ser = 0; e_act = 0; e_done = 0;
      if (m_frame && cyc >= m_t0 && cyc < m_t0 + m_len) begin
        e_act = 1;
        e_ser = m_flit[cyc - m_t0];
      end
      if (m_frame && cyc == m_t0 + m_len) e_done = 1;
    end
    #1;
    check("serial_out", serial_out, e_ser);
    check("tx_active",  tx_active,  e_act);
    check("done",       done,       e_done);
    check("overrun",    overrun,    e_ovr);
    if (overrun) ovr_seen++;
  endtask

  task automatic rand_junk();
    enc_flit         = {$urandom, $urandom};
    comma_length_sel = 2'($urandom_range(0, 3));
  endtask

  // Launch one frame and collect the lane until done, with a cycle budget.
  task automatic run_frame(input string name, input logic [1:0] sel,
                           input logic [ENC_W-1:0] flit, input int exp_bits,
                           input logic [ENC_W-1:0] exp_stream);
    int t, nb, doff;
    logic [ENC_W-1:0] got;
    start = 1'b1; comma_length_sel = sel; enc_flit = flit;
    step();
    t = cyc; start = 1'b0; rand_junk();
    got = '0; nb = 0; doff = -1;
    if (tx_active) begin got[0] = serial_out; nb = 1; end
    for (int k = 0; k < 120 && doff < 0; k++) begin
      step();
      if (tx_active && nb < ENC_W) begin got[nb] = serial_out; nb++; end
      if (done) doff = cyc - t;
    end
    check({name, " bits"}, nb, exp_bits);
    check({name, " done_offset"}, doff, exp_bits);
    checks++;
    if (got !== exp_stream) begin
      errors++;
      $display("FAIL %s stream: got %h expected %h", name, got, exp_stream);
    end
  endtask

  initial begin
    int t, doff;

    vecs[0] = '{2'b00, 50'h2_AAAA_5555_F0F0, 50, 50'h2_AAAA_5555_F0F0};
    vecs[1] = '{2'b01, 50'h3_FFFF_FFFF_FCFA, 10, 50'h0FA};
    vecs[2] = '{2'b10, 50'h3_1234_5678_9ABC, 20, 50'h8_9ABC};
    vecs[3] = '{2'b11, 50'h1_5A5A_C3C3_0F0F, 50, 50'h1_5A5A_C3C3_0F0F};

    nRST = 1'b0; start = 1'b0; enc_flit = '1; comma_length_sel = 2'b00;
    ovr_seen = 0;
    step();
    step();
    nRST = 1'b1;
    step();

    // Length selections: full, 1 symbol, 2 symbols, reserved.
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].flit,
                vecs[i].exp_bits, vecs[i].exp_stream);
      step();
      step();
    end

    // Overrun: second start 5 edges into a full frame is dropped.
    ovr_seen = 0;
    start = 1'b1; comma_length_sel = 2'b00; enc_flit = 50'h2_AAAA_5555_F0F0;
    step();
    t = cyc; start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    start = 1'b1; comma_length_sel = 2'b01; enc_flit = '0;
    step();
    start = 1'b0;
    doff = -1;
    for (int k = 0; k < 120 && doff < 0; k++) begin
      step();
      if (done) doff = cyc - t;
    end
    check("overrun done_offset", doff, 50);
    for (int k = 0; k < 8; k++) step();
    check("overrun pulses", ovr_seen, 1);

    // Back-to-back: start during the done cycle.
    start = 1'b1; comma_length_sel = 2'b00; enc_flit = 50'h1_2345_6789_ABCD;
    step();
    t = cyc; start = 1'b0;
    doff = -1;
    for (int k = 0; k < 120 && doff < 0; k++) begin
      step();
      if (done) doff = cyc - t;
    end
    check("b2b first done", doff, 50);
    start = 1'b1; comma_length_sel = 2'b00; enc_flit = 50'h3_0F0F_F0F0_1234;
    step();
    start = 1'b0;
    check("b2b second active", tx_active, 1);
    doff = -1;
    for (int k = 0; k < 120 && doff < 0; k++) begin
      step();
      if (done) doff = cyc - t;
    end
    check("b2b second done", doff, 101);
    step();

    // Reset mid-frame aborts, then a clean frame follows.
    start = 1'b1; comma_length_sel = 2'b00; enc_flit = 50'h2_AAAA_5555_F0F0;
    step();
    start = 1'b0;
    for (int k = 0; k < 19; k++) step();
    nRST = 1'b0;
    step();
    check("reset tx_active", tx_active, 0);
    check("reset done", done, 0);
    nRST = 1'b1;
    for (int k = 0; k < 40; k++) step();
    run_frame("post_reset", 2'b00, 50'h1_5A5A_C3C3_0F0F, 50, 50'h1_5A5A_C3C3_0F0F);
    step();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      nRST  = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 9) == 0);
      rand_junk();
      step();
    end
    nRST = 1'b1; start = 1'b0;
    for (int k = 0; k < 60; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
